dzcpu_timer: RTL and testbench
==============================

Name: dzcpu_timer

Overview:
- Memory-mapped DIV/TIMA/TMA/TAC timer on the CPU memory bus, downstream of the CPU core.
- Decodes CPU address/write-enable for 0xFF04–0xFF07 and returns read data to the bus read mux.
- Drives a one-cycle timer interrupt request to the interrupt logic.
- Sequential: 16-bit free-running divider, falling-edge detector, TIMA counter, overflow/reload state machine.

Parameters:
- RELOAD_DELAY, 4, clocks between TIMA overflow and TMA reload/IRQ; legal range 1–15.

Ports:
- iClock  input  1  system clock, one clock domain
- iReset  input  1  synchronous, active-high reset
- iMCUAddr  input  16  CPU bus address
- iMCUData  input  8  CPU write data
- iMCUwe  input  1  CPU write strobe, one cycle per write
- oData  output  8  register read data, combinational from iMCUAddr; 8'hFF when not hit
- oHit  output  1  combinational; 1 when iMCUAddr in 0xFF04–0xFF07
- oTimerIrq  output  1  registered one-cycle pulse on TMA reload

Behaviour:
- Clock and reset: one clock iClock; reset iReset is synchronous and active-high. Reset applies on an iClock edge with iReset=1.
- Reset values: divider=16'h0000, TIMA=0, TMA=0, TAC=3'b000, state=RUN, delay counter=0, oTimerIrq=0, edge-history flop=0.
- Divider:
  - 16-bit counter; +1 every clock; wraps 16'hFFFF -> 0.
  - DIV (0xFF04) reads as divider[15:8].
  - Any write to 0xFF04 clears the divider to 0 on the next edge; write data is ignored.
- TAC (0xFF07):
  - Only bits[2:0] are stored; reads as {5'b11111, TAC}.
  - TAC[2] is the enable. TAC[1:0] selects the divider tap: 00->bit9, 01->bit3, 10->bit5, 11->bit7.
- Tick:
  - tap = TAC[2] & divider[sel].
  - The edge-history flop stores tap every clock.
  - tick = history & ~tap (falling edge).
  - Divider clears and TAC writes can therefore create a tick. This is intentional and matches DMG behaviour.
- TIMA (0xFF05) / TMA (0xFF06): plain 8-bit read/write.
- State machine:
  - RUN: on tick, TIMA+1. If TIMA==8'hFF, TIMA becomes 0x00, delay counter is loaded with RELOAD_DELAY-1, and the state goes to RELOAD.
  - RELOAD:
    - TIMA reads 0x00. Ticks are ignored.
    - Delay counter decrements each clock.
    - When it is 0: TIMA<=TMA (value current in that cycle), oTimerIrq=1 for exactly that cycle, state->RUN.
    - With RELOAD_DELAY=1, the reload happens on the clock after overflow.
- Write priority in the same cycle:
  - CPU write to TIMA beats tick increment.
  - CPU write to TIMA in RELOAD cancels the reload and the IRQ; state->RUN with the written value.
  - CPU write to TMA on the reload cycle: the new value is loaded into TIMA.
- iMCUwe with an address outside 0xFF04–0xFF07: no state change.
- Reset mid-RELOAD: returns to RUN with no IRQ pulse.
- oData/oHit are purely combinational. They are valid in the same cycle the CPU presents the address; zero read latency.

Test Plan:
- Reset then 256 clocks -> DIV reads 0x01; after 65536 clocks divider wraps, DIV=0x00; oTimerIrq stays 0 throughout (TAC=0).
- TAC=3'b101 (enable, /16), TMA=0xAB, TIMA=0xFE -> after 32 clocks TIMA=0x00 for RELOAD_DELAY clocks, then TIMA=0xAB with a single oTimerIrq pulse; next increment to 0xAC after 16 more clocks.
- Overflow with TAC=3'b101, then write TIMA=0x55 two clocks after overflow -> no IRQ pulse, TIMA=0x55, counting resumes.
- TAC=3'b100 (/1024), divider bit9=1, write to DIV -> TIMA increments by 1 immediately (falling edge), divider=0.
- Read 0xFF07 after writing 0xFF -> 0xFF; after writing 0x00 -> 0xF8; read 0xC000 -> oHit=0, oData=0xFF.
- Assert iReset during RELOAD -> all registers 0, oTimerIrq never pulses, DIV restarts from 0x00.

Source files
------------

// File: rtl/dzcpu_timer.sv
// dzcpu_timer: DMG-style DIV/TIMA/TMA/TAC timer with delayed TMA reload and interrupt
module dzcpu_timer #(
  parameter int RELOAD_DELAY = 4
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iMCUAddr,
  input  logic [7:0]  iMCUData,
  input  logic        iMCUwe,
  output logic [7:0]  oData,
  output logic        oHit,
  output logic        oTimerIrq
);
  typedef enum logic {RUN, RELOAD} state_t;
  localparam logic [3:0] RELOAD_CNT = 4'(RELOAD_DELAY - 1);
  state_t      state_q, state_d;
  logic [15:0] div_q;
  logic [7:0]  tima_q, tima_d, tma_q;
  logic [2:0]  tac_q;
  logic [3:0]  cnt_q, cnt_d, tap_idx;
  logic        hist_q, irq_q, irq_d, tap, tick;
  logic        wr_div, wr_tima, wr_tma, wr_tac;
  assign oHit      = iMCUAddr[15:2] == 14'h3FC1;
  assign wr_div    = iMCUwe & oHit & (iMCUAddr[1:0] == 2'd0);
  assign wr_tima   = iMCUwe & oHit & (iMCUAddr[1:0] == 2'd1);
  assign wr_tma    = iMCUwe & oHit & (iMCUAddr[1:0] == 2'd2);
  assign wr_tac    = iMCUwe & oHit & (iMCUAddr[1:0] == 2'd3);
  assign tap_idx   = tac_q[1:0] == 2'd0 ? 4'd9 : tac_q[1:0] == 2'd1 ? 4'd3 :
                     tac_q[1:0] == 2'd2 ? 4'd5 : 4'd7;
  assign tap       = tac_q[2] & div_q[tap_idx];
  assign tick      = hist_q & ~tap;
  assign oTimerIrq = irq_q;
  // zero-latency register read mux
  always_comb begin
    oData = !oHit ? 8'hFF :
            iMCUAddr[1:0] == 2'd0 ? div_q[15:8] :
            iMCUAddr[1:0] == 2'd1 ? tima_q :
            iMCUAddr[1:0] == 2'd2 ? tma_q : {5'b11111, tac_q};
  end
  // divider, TMA, TAC and falling-edge history; a DIV clear or TAC write can drop the tap and tick
  always_ff @(posedge iClock) begin
    if (iReset) begin
      div_q  <= '0;
      tma_q  <= '0;
      tac_q  <= '0;
      hist_q <= 1'b0;
    end else begin
      div_q  <= wr_div ? 16'h0000 : div_q + 16'd1;
      tma_q  <= wr_tma ? iMCUData : tma_q;
      tac_q  <= wr_tac ? iMCUData[2:0] : tac_q;
      hist_q <= tap;
    end
  end
  // TIMA count/overflow; a CPU TIMA write beats ticks and cancels a pending reload
  always_comb begin
    state_d = state_q;
    tima_d  = tima_q;
    cnt_d   = cnt_q;
    irq_d   = 1'b0;
    if (wr_tima) begin
      tima_d  = iMCUData;
      state_d = RUN;
    end else if (state_q == RELOAD) begin
      if (cnt_q == 4'd0) begin
        tima_d  = wr_tma ? iMCUData : tma_q;
        irq_d   = 1'b1;
        state_d = RUN;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (tick) begin
      tima_d = tima_q + 8'd1;
      if (tima_q == 8'hFF) begin
        cnt_d   = RELOAD_CNT;
        state_d = RELOAD;
      end
    end
  end
  // timer state registers
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= RUN;
      tima_q  <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tima_q  <= tima_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end
endmodule

// File: tb/tb_dzcpu_timer.sv
// tb_dzcpu_timer: randomized and directed checks of dzcpu_timer against a behavioural model
module tb_dzcpu_timer;
  localparam int RD = 4;
  logic        clk = 1'b0, rst = 1'b0, we = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  data = 8'h00, rdata;
  logic        hit, irq;
  int total = 0, bad = 0, irq_seen = 0;
  int m_div, m_tima, m_tma, m_tac, m_hist, m_age;
  bit m_irq;

  dzcpu_timer #(.RELOAD_DELAY(RD)) dut (
    .iClock(clk), .iReset(rst), .iMCUAddr(addr), .iMCUData(data),
    .iMCUwe(we), .oData(rdata), .oHit(hit), .oTimerIrq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_rd(input logic [15:0] a);
    if (a < 16'hFF04 || a > 16'hFF07) return 8'hFF;
    if (a == 16'hFF04) return 8'(m_div / 256);
    if (a == 16'hFF05) return 8'(m_tima);
    if (a == 16'hFF06) return 8'(m_tma);
    return 8'(248 + m_tac);
  endfunction

  task automatic m_step(input bit r, input logic [15:0] a, input logic [7:0] d, input bit w);
    int sh, tap, tick;
    m_irq = 0;
    if (r) begin
      m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_hist = 0; m_age = -1;
      return;
    end
    sh = (m_tac % 4 == 0) ? 9 : (m_tac % 4 == 1) ? 3 : (m_tac % 4 == 2) ? 5 : 7;
    tap = (m_tac >= 4) ? (m_div >> sh) % 2 : 0;
    tick = m_hist && !tap;
    m_hist = tap;
    if (w && a == 16'hFF05) begin
      m_tima = d; m_age = -1;
    end else if (m_age >= 0) begin
      m_age++;
      if (m_age == RD) begin
        m_tima = (w && a == 16'hFF06) ? int'(d) : m_tma;
        m_irq = 1;
        m_age = -1;
      end
    end else if (tick) begin
      m_tima++;
      if (m_tima == 256) begin m_tima = 0; m_age = 0; end
    end
    if (w && a == 16'hFF06) m_tma = d;
    if (w && a == 16'hFF07) m_tac = d % 8;
    m_div = (w && a == 16'hFF04) ? 0 : (m_div + 1) % 65536;
  endtask

  task automatic cyc(input bit r, input logic [15:0] a, input logic [7:0] d, input bit w);
    rst = r; addr = a; data = d; we = w;
    #1;
    chk("hit", 16'(hit), 16'(a >= 16'hFF04 && a <= 16'hFF07));
    chk("rd", 16'(rdata), 16'(m_rd(a)));
    @(posedge clk);
    m_step(r, a, d, w);
    #1;
    chk("irq", 16'(irq), 16'(m_irq));
    if (irq) irq_seen++;
    rst = 1'b0; we = 1'b0;
  endtask

  task automatic peek(input string tag, input logic [15:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    chk(tag, 16'(rdata), 16'(exp));
  endtask

  task automatic wait_ovf();
    bit found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      cyc(0, 16'hFF05, 8'h00, 0);
      found = (m_age == 0);
    end
    chk("ovf_seen", 16'(found), 16'd1);
  endtask

  initial begin
    m_age = -1;
    @(negedge clk);
    // reset, DIV rate and wrap with timer disabled
    cyc(1, 16'hFF04, 8'h00, 0);
    irq_seen = 0;
    for (int i = 0; i < 256; i++) cyc(0, 16'hFF04, 8'h00, 0);
    peek("div256", 16'hFF04, 8'h01);
    for (int i = 256; i < 65536; i++) cyc(0, 16'hFF04, 8'h00, 0);
    peek("div_wrap", 16'hFF04, 8'h00);
    chk("irq_idle", 16'(irq_seen), 16'd0);
    // overflow, delayed reload to TMA, single IRQ
    cyc(1, 16'hFF04, 8'h00, 0);
    cyc(0, 16'hFF07, 8'h05, 1);
    cyc(0, 16'hFF06, 8'hAB, 1);
    cyc(0, 16'hFF05, 8'hFE, 1);
    irq_seen = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(0, 16'hFF05, 8'h00, 0);
      if (irq) chk("reload_val", 16'(rdata), 16'h00AB);
    end
    chk("irq_once", 16'(irq_seen), 16'd1);
    // TIMA write during reload cancels it
    cyc(0, 16'hFF05, 8'hFE, 1);
    wait_ovf();
    irq_seen = 0;
    cyc(0, 16'hFF05, 8'h00, 0);
    cyc(0, 16'hFF05, 8'h55, 1);
    peek("cancel_val", 16'hFF05, 8'h55);
    for (int i = 0; i < 30; i++) cyc(0, 16'hFF05, 8'h00, 0);
    chk("irq_cancel", 16'(irq_seen), 16'd0);
    // DIV write with tapped bit high creates a tick
    cyc(1, 16'hFF04, 8'h00, 0);
    cyc(0, 16'hFF07, 8'h04, 1);
    cyc(0, 16'hFF05, 8'h10, 1);
    for (int i = 0; i < 1100 && m_div % 1024 != 768; i++) cyc(0, 16'hFF05, 8'h00, 0);
    cyc(0, 16'hFF04, 8'h77, 1);
    cyc(0, 16'hFF05, 8'h00, 0);
    peek("div_tick", 16'hFF05, 8'h11);
    peek("div_clr", 16'hFF04, 8'h00);
    // TAC readback and unmapped address
    cyc(0, 16'hFF07, 8'hFF, 1);
    peek("tac_ff", 16'hFF07, 8'hFF);
    cyc(0, 16'hFF07, 8'h00, 1);
    peek("tac_00", 16'hFF07, 8'hF8);
    peek("miss_rd", 16'hC000, 8'hFF);
    chk("miss_hit", 16'(hit), 16'd0);
    cyc(0, 16'hC005, 8'h33, 1);
    peek("miss_wr", 16'hFF05, 8'h11);
    // reset in the middle of a reload
    cyc(0, 16'hFF07, 8'h05, 1);
    cyc(0, 16'hFF06, 8'h9C, 1);
    cyc(0, 16'hFF05, 8'hFF, 1);
    wait_ovf();
    irq_seen = 0;
    cyc(0, 16'hFF05, 8'h00, 0);
    cyc(1, 16'hFF05, 8'h00, 0);
    peek("rst_tima", 16'hFF05, 8'h00);
    peek("rst_tma", 16'hFF06, 8'h00);
    peek("rst_tac", 16'hFF07, 8'hF8);
    peek("rst_div", 16'hFF04, 8'h00);
    for (int i = 0; i < 10; i++) cyc(0, 16'hFF04, 8'h00, 0);
    chk("irq_rst", 16'(irq_seen), 16'd0);
    // randomized traffic
    for (int i = 0; i < 20000; i++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 9) < 8) ? 16'hFF04 + 16'($urandom_range(0, 3)) : 16'($urandom);
      cyc($urandom_range(0, 1999) == 0, a, 8'($urandom), $urandom_range(0, 5) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
